// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid FIFO and valid/ready on both sides.
// Optional illegal-mode flag storage is enabled by defining EXT_ILLEGAL_CHK_EN.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int DEPTH = 2;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input logic [2:0] mode);
    logic [OUT_W-1:0] s_ext;
    logic [OUT_W-1:0] z_ext;
    logic [OUT_W-1:0] res;
    s_ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    z_ext = {{(OUT_W-IN_W){1'b0}}, imm};
    case (mode)
      3'b000:  res = s_ext;
      3'b001:  res = z_ext;
      3'b010:  res = {imm, {(OUT_W-IN_W){1'b0}}};
      3'b011:  res = s_ext << 2;
      3'b100:  res = z_ext << 2;
      default: res = '0;
    endcase
    return res;
  endfunction

  logic             in_ready_reg;
  logic [1:0]       count_reg, count_next;
  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;
  logic [OUT_W-1:0] data_reg [DEPTH];
  logic [OUT_W-1:0] ext_value;
  logic             push;
  logic             pop;

  // in_ready is a register so the input side never sees out_ready combinationally
  assign push      = in_valid & in_ready_reg & ~flush;
  assign pop       = (count_reg != 2'd0) & out_ready;
  assign ext_value = extend(in_imm, in_mode);

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      in_ready_reg <= 1'b1;
    end else begin
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      in_ready_reg <= (count_next != 2'd2);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg[gi] <= ext_value;
        end
      end
    end
  endgenerate

`ifdef EXT_ILLEGAL_CHK_EN
  logic err_reg [DEPTH];

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_err
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          err_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          err_reg[gi] <= (in_mode > 3'd4);
        end
      end
    end
  endgenerate

  assign out_err = err_reg[rd_ptr_reg];
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = data_reg[rd_ptr_reg];

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

- Parametrised, pipelined immediate extender; successor to the single-cycle combinational extender.
- Sits between decode and execute, with a valid/ready handshake on both sides.
- Accepts an IN_W-bit immediate plus a mode, and returns the OUT_W-bit extended value one cycle later.
- A 2-entry skid buffer gives full throughput under backpressure; `flush` discards in-flight entries on branch/exception redirect.

## Interface
Parameters:
- IN_W, 16: immediate width. Must be ≥ 2.
- OUT_W, 32: result width. Must be ≥ IN_W + 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard all buffered entries and any same-cycle input.
- in_valid  in  1  input entry present.
- in_ready  out  1  block can accept an entry this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  3  extension mode.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  OUT_W  extended result.
- out_err  out  1  illegal mode flag. Only active with EXT_ILLEGAL_CHK_EN.

## Operation
Modes (S = sign extension of in_imm to OUT_W, Z = zero extension):
- 3'b000: S.
- 3'b001: Z.
- 3'b010: upper. in_imm is placed in bits [OUT_W-1 : OUT_W-IN_W]; lower bits are 0.
- 3'b011: S << 2, branch offset. Bits shifted out are dropped.
- 3'b100: Z << 2, jump-index form.
- 3'b101–3'b111: illegal. out_data = 0.

Buffering:
- Handshakes: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Results are computed at input transfer and stored with their mode, in a 2-entry FIFO (head = out_data).
- in_ready = count < 2. in_ready is registered, so it never depends combinationally on out_ready.
- out_valid = count > 0.
- out_data and out_err are driven from the head entry. They stay stable while out_valid & !out_ready.
- Simultaneous input and output transfer:
  - at count 1, count stays 1 and the new entry becomes head;
  - at count 2, the transfer cannot occur because in_ready = 0.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush or reset.

Flush:
- Next edge: count = 0 and out_valid = 0.
- The same-cycle input is not stored, even if in_ready = 1.
- A same-cycle output transfer is still counted as delivered by the consumer.

Reset:
- Reset wins over flush and all handshakes.
- After the edge with rst_n = 0: count = 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
- Reset mid-stream discards every buffered entry.

## Timing
- Latency: input accepted at edge N → out_valid = 1 after edge N. Result is visible in cycle N+1.
- Throughput: 1 entry per cycle while out_ready is held high.
- Backpressure: with out_ready low, two entries are accepted, then in_ready falls after the edge that filled entry 2.
- in_ready rises the cycle after the first output transfer from full.
- Flush asserted in cycle N → out_valid = 0 in cycle N+1; in_ready = 1 in cycle N+1.

## Configuration
- EXT_ILLEGAL_CHK_EN defined:
  - modes 5–7 store out_err = 1 with out_data = 0;
  - out_err travels with its entry and is valid only while out_valid.
- EXT_ILLEGAL_CHK_EN undefined:
  - out_err is tied to 0;
  - illegal modes still produce out_data = 0;
  - no extra storage bit is implemented.

## Test plan
All scenarios use IN_W=16, OUT_W=32.
1. Reset then a single entry, in_imm=16'h8001, mode 000, out_ready=1 → next cycle out_valid=1, out_data=32'hFFFF8001; following cycle out_valid=0.
2. Back-to-back entries 16'h8001 in modes 001, 010, 011, 100 with out_ready=1 → results 32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h00020004 on consecutive cycles.
3. out_ready=0 with 3 offered entries (A,B,C) → A and B accepted; in_ready=0 while C is held; out_data stays A. Raise out_ready → A, B, C delivered in order with no gaps after C is accepted.
4. Buffer holds 2 entries, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed input never appears.
5. rst_n=0 for one cycle while full, with out_ready=1 → next cycle out_valid=0, out_data=0, out_err=0, in_ready=1.
6. in_imm=16'h1234, mode 110 → out_data=0. With EXT_ILLEGAL_CHK_EN: out_err=1. Without it: out_err=0.
